imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the instruction-memory loader.
//   state_t       : loader FSM state encoding
//   MAGIC_DEFAULT : default frame start byte
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// imem_loader -- receives a framed program image over a byte stream and
// writes it into instruction memory, holding the core in reset until the
// whole frame has arrived with a good checksum.
//   Frame: MAGIC, N[7:0], N[15:8], 4*N payload bytes, sum-mod-256 checksum.
// Ports:
//   clk, rst            clock, async active-high reset
//   rx_data, rx_valid   incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready
//   wr_en/addr/data     one-cycle instruction-memory word write
//   cpu_rst             core held in reset unless the load completed cleanly
//   busy, done, err     mutually exclusive status flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, nxt;
    logic [15:0]   n_len;
    logic [15:0]   word_idx;
    logic [1:0]    bcnt;
    logic [23:0]   shreg;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;

    logic acc, active, is_magic, start, timeout, word_done, last_word;

    assign rx_ready  = ~rst;
    assign acc       = rx_valid & rx_ready;
    assign is_magic  = (rx_data == MAGIC);
    assign active    = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
    // A new frame can begin from idle or from either terminal state.
    assign start     = acc && is_magic &&
                       ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    // tcnt counts idle cycles already elapsed; this cycle is the last allowed.
    assign timeout   = active && !acc && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign word_done = (state == S_DATA) && acc && (bcnt == 2'd3);
    assign last_word = (word_idx == n_len - 16'd1);

    assign busy    = active;
    assign done    = (state == S_DONE);
    assign err     = (state == S_ERR);
    assign cpu_rst = (state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_LEN0;
            S_LEN0:  if (acc) nxt = S_LEN1;
            S_LEN1:  if (acc) nxt = ({rx_data, n_len[7:0]} == 16'd0) ? S_CSUM : S_DATA;
            S_DATA:  if (word_done && last_word) nxt = S_CSUM;
            S_CSUM:  if (acc) nxt = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:   if (start) nxt = S_LEN0;
            default: nxt = S_IDLE;
        endcase
        if (timeout) nxt = S_ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            n_len    <= '0;
            word_idx <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            csum     <= '0;
            tcnt     <= '0;
        end else begin
            wr_en <= 1'b0;

            if (!active || acc) tcnt <= '0;
            else                tcnt <= tcnt + TW'(1);

            if (start) begin
                n_len    <= '0;
                word_idx <= '0;
                bcnt     <= '0;
                csum     <= '0;
            end

            case (state)
                S_LEN0: if (acc) n_len[7:0]  <= rx_data;
                S_LEN1: if (acc) n_len[15:8] <= rx_data;
                S_DATA: if (acc) begin
                    csum  <= csum + rx_data;
                    bcnt  <= bcnt + 2'd1;
                    // Bytes enter at the top so the first lands at [7:0].
                    shreg <= {rx_data, shreg[23:8]};
                    if (bcnt == 2'd3) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= {14'd0, word_idx, 2'b00};
                        wr_data  <= {rx_data, shreg};
                        word_idx <= word_idx + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
